// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - bus bundle between writeback buffer, load-return unit and register-file port
interface wb_port_arbiter_if #(
    parameter int N     = 18,
    parameter int LANES = 3
);
    logic                      pipe_we;
    logic [3:0]                pipe_wa;
    logic [LANES-1:0][N-1:0]   pipe_wd;
    logic                      mem_valid;
    logic [3:0]                mem_wa;
    logic [LANES-1:0][N-1:0]   mem_wd;
    logic                      mem_ready;
    logic                      wb_load;
    logic                      stall_o;
    logic                      rf_we;
    logic [3:0]                rf_wa;
    logic [LANES-1:0][N-1:0]   rf_wd;
    logic [15:0]               perf_stall_cnt;
    logic [15:0]               perf_mem_cnt;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, mem_valid, mem_wa, mem_wd,
        output mem_ready, wb_load, stall_o, rf_we, rf_wa, rf_wd,
               perf_stall_cnt, perf_mem_cnt
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd, mem_valid, mem_wa, mem_wd,
        input  mem_ready, wb_load, stall_o, rf_we, rf_wa, rf_wd,
               perf_stall_cnt, perf_mem_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter, pipeline first, starved load return forced in
// Optional feature macro: WB_PERF_EN builds the forced-stall and load-return counters.
module wb_port_arbiter #(
    parameter int N        = 18,
    parameter int LANES    = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic {S_PIPE = 1'b0, S_STALL = 1'b1} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t                  state, state_nx;
    logic [3:0]              wait_cnt, wait_cnt_nx;
    logic                    grant_pipe, grant_mem;
    logic                    wb_load, stall;
    logic                    rf_we;
    logic [3:0]              rf_wa;
    logic [LANES-1:0][N-1:0] rf_wd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_PIPE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // A request present while reset is held is never acknowledged; the requester reissues.
    always_comb begin
        state_nx    = S_PIPE;
        wait_cnt_nx = '0;
        grant_pipe  = 1'b0;
        grant_mem   = 1'b0;
        wb_load     = 1'b1;
        stall       = 1'b0;
        case (state)
            S_PIPE: begin
                if (bus.pipe_we) begin
                    grant_pipe = 1'b1;
                    if (bus.mem_valid) begin
                        if (wait_cnt == WAIT_LAST) state_nx = S_STALL;
                        else wait_cnt_nx = wait_cnt + 4'd1;
                    end
                end else begin
                    grant_mem = bus.mem_valid;
                end
            end
            S_STALL: begin
                wb_load   = 1'b0;
                stall     = 1'b1;
                grant_mem = bus.mem_valid;
            end
        endcase
        if (!reset) begin
            grant_pipe = 1'b0;
            grant_mem  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= grant_pipe | grant_mem;
            if (grant_pipe) begin
                rf_wa <= bus.pipe_wa;
                rf_wd <= bus.pipe_wd;
            end else if (grant_mem) begin
                rf_wa <= bus.mem_wa;
                rf_wd <= bus.mem_wd;
            end
        end
    end

`ifdef WB_PERF_EN
    logic [15:0] stall_cnt, mem_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            mem_cnt   <= '0;
        end else begin
            if (state == S_STALL && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (grant_mem && mem_cnt != 16'hFFFF) mem_cnt <= mem_cnt + 16'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_mem_cnt   = mem_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_mem_cnt   = '0;
`endif

    assign bus.mem_ready = grant_mem;
    assign bus.wb_load   = wb_load;
    assign bus.stall_o   = stall;
    assign bus.rf_we     = rf_we;
    assign bus.rf_wa     = rf_wa;
    assign bus.rf_wd     = rf_wd;
endmodule
